// File: rtl/pcie_tx_pkg.sv
// rtl/pcie_tx_pkg.sv - symbol codes, scheduler states and ordered-set helpers
package pcie_tx_pkg;

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_IDL = 8'h7C;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] LIDL  = 8'h00;

    // COM plus three IDL symbols in the electrical-idle ordered set
    localparam logic [2:0] EIOS_LEN = 3'd4;

    typedef enum logic [2:0] {
        ST_EI     = 3'd0,
        ST_WAKE   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_SKP    = 3'd3,
        ST_EIOS   = 3'd4
    } tx_state_t;

    function automatic logic is_frame_start(input logic [7:0] data, input logic k);
        return k && (data == K_STP || data == K_SDP);
    endfunction

    function automatic logic is_frame_end(input logic [7:0] data, input logic k);
        return k && (data == K_END || data == K_EDB);
    endfunction

endpackage

// File: rtl/pcie_skp_timer.sv
// rtl/pcie_skp_timer.sv - saturating SKP interval counter
module pcie_skp_timer #(
    parameter int INTERVAL = 1180
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic due
);

    localparam int            W    = $clog2(INTERVAL);
    localparam logic [W-1:0]  TERM = W'(INTERVAL - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && count != TERM) begin
            count <= count + 1'b1;
        end
    end

    assign due = (count == TERM);

endmodule

// File: rtl/pcie_tx_sched.sv
// rtl/pcie_tx_sched.sv - TX symbol scheduler: source frames, SKP and EIOS ordered sets, idle sequencing
module pcie_tx_sched
    import pcie_tx_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3,
    parameter int WAKE_CYCLES  = 16
) (
    input  logic       PCLK250,
    input  logic       CNTL_RESETN_P0,
    input  logic       CFG_Enable,
    input  logic       CFG_ElecIdleReq,
    input  logic       SRC_Valid,
    input  logic [7:0] SRC_Data,
    input  logic       SRC_DataK,
    output logic       SRC_Ready,
    output logic [7:0] TXDATA,
    output logic       TXDATAK,
    output logic       TXELECIDLE,
    output logic       CNTL_TXEnable_P0,
    output logic [2:0] STAT_State,
    output logic       STAT_SkpDue
);

    localparam int             WW        = $clog2(WAKE_CYCLES + 1);
    localparam logic [WW-1:0]  WAKE_LAST = WW'(WAKE_CYCLES - 1);
    localparam logic [2:0]     SKP_LAST  = 3'(SKP_COUNT);

    tx_state_t      state, state_nxt;
    logic           in_frame, in_frame_nxt;
    logic [2:0]     os_cnt, os_cnt_nxt;
    logic [WW-1:0]  wake_cnt, wake_cnt_nxt;
    logic [7:0]     data_nxt;
    logic           k_nxt, eidle_nxt, txen_nxt;
    logic           skp_due, skp_clear, stop_req, accept;

    assign stop_req  = CFG_ElecIdleReq | ~CFG_Enable;
    assign SRC_Ready = (state == ST_ACTIVE) & ~(stop_req & ~in_frame) & ~(skp_due & ~in_frame);
    assign accept    = SRC_Valid & SRC_Ready;

    pcie_skp_timer #(.INTERVAL(SKP_INTERVAL)) u_skp_timer (
        .clk   (PCLK250),
        .rst_n (CNTL_RESETN_P0),
        .run   (state != ST_EI),
        .clear (skp_clear),
        .due   (skp_due)
    );

    always_ff @(posedge PCLK250 or negedge CNTL_RESETN_P0) begin
        if (!CNTL_RESETN_P0) begin
            state            <= ST_EI;
            in_frame         <= 1'b0;
            os_cnt           <= '0;
            wake_cnt         <= '0;
            TXDATA           <= 8'h00;
            TXDATAK          <= 1'b0;
            TXELECIDLE       <= 1'b1;
            CNTL_TXEnable_P0 <= 1'b0;
        end else begin
            state            <= state_nxt;
            in_frame         <= in_frame_nxt;
            os_cnt           <= os_cnt_nxt;
            wake_cnt         <= wake_cnt_nxt;
            TXDATA           <= data_nxt;
            TXDATAK          <= k_nxt;
            TXELECIDLE       <= eidle_nxt;
            CNTL_TXEnable_P0 <= txen_nxt;
        end
    end

    // Ordered sets register their COM on the entry edge; os_cnt then counts symbols already sent.
    always_comb begin
        state_nxt    = state;
        in_frame_nxt = in_frame;
        os_cnt_nxt   = os_cnt;
        wake_cnt_nxt = wake_cnt;
        data_nxt     = LIDL;
        k_nxt        = 1'b0;
        eidle_nxt    = 1'b0;
        txen_nxt     = 1'b1;
        skp_clear    = 1'b0;
        case (state)
            ST_EI: begin
                eidle_nxt    = 1'b1;
                txen_nxt     = 1'b0;
                wake_cnt_nxt = '0;
                if (CFG_Enable && !CFG_ElecIdleReq) begin
                    state_nxt = ST_WAKE;
                    eidle_nxt = 1'b0;
                    txen_nxt  = 1'b1;
                end
            end
            ST_WAKE: begin
                if (stop_req) begin
                    data_nxt   = K_COM;
                    k_nxt      = 1'b1;
                    os_cnt_nxt = 3'd1;
                    state_nxt  = ST_EIOS;
                end else if (wake_cnt == WAKE_LAST) begin
                    state_nxt = ST_ACTIVE;
                end else begin
                    wake_cnt_nxt = wake_cnt + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!in_frame && stop_req) begin
                    data_nxt   = K_COM;
                    k_nxt      = 1'b1;
                    os_cnt_nxt = 3'd1;
                    state_nxt  = ST_EIOS;
                end else if (!in_frame && skp_due) begin
                    data_nxt   = K_COM;
                    k_nxt      = 1'b1;
                    os_cnt_nxt = 3'd1;
                    skp_clear  = 1'b1;
                    state_nxt  = ST_SKP;
                end else if (accept) begin
                    data_nxt = SRC_Data;
                    k_nxt    = SRC_DataK;
                    if (is_frame_start(SRC_Data, SRC_DataK)) begin
                        in_frame_nxt = 1'b1;
                    end else if (is_frame_end(SRC_Data, SRC_DataK)) begin
                        in_frame_nxt = 1'b0;
                    end
                end
            end
            ST_SKP: begin
                data_nxt = K_SKP;
                k_nxt    = 1'b1;
                if (os_cnt == SKP_LAST) begin
                    state_nxt = ST_ACTIVE;
                end else begin
                    os_cnt_nxt = os_cnt + 1'b1;
                end
            end
            ST_EIOS: begin
                if (os_cnt == EIOS_LEN) begin
                    state_nxt = ST_EI;
                    eidle_nxt = 1'b1;
                    txen_nxt  = 1'b0;
                end else begin
                    data_nxt   = K_IDL;
                    k_nxt      = 1'b1;
                    os_cnt_nxt = os_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EI;
            end
        endcase
    end

    assign STAT_State  = state;
    assign STAT_SkpDue = skp_due;

endmodule
